// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the program counter, addresses an asynchronous
// instruction ROM and holds one fetched word for decode behind a valid/ready
// handshake. Supports jumps with flush, halt/resume and a delivered-word count.
module instr_fetch #(
  parameter int unsigned           ROM_WIDTH    = 21,
  parameter int unsigned           ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [ROM_WIDTH-1:0]  ROM_DATA,
  output logic [ROM_WIDTH-1:0]  INSTR,
  output logic [ADDR_WIDTH-1:0] INSTR_PC,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  input  logic                  JUMP_EN,
  input  logic [ADDR_WIDTH-1:0] JUMP_ADDR,
  input  logic                  HALT_REQ,
  input  logic                  RESUME,
  output logic                  HALTED,
  output logic [15:0]           FETCH_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ROM_WIDTH-1:0]  instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [15:0]           fetch_cnt_q, fetch_cnt_d;

  logic accept;
  logic slot_free;

  assign accept    = instr_valid_q & INSTR_READY;
  assign slot_free = ~instr_valid_q | accept;

  // Next-state and datapath: jump beats halt, halt beats resume, resume beats fetch.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned, which would infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    // The count is independent of jumps and halts: every handshake counts.
    fetch_cnt_d   = fetch_cnt_q + 16'(accept);

    if (JUMP_EN) begin
      // Redirect and flush the wrong-path word; the first target word is fetched next cycle.
      pc_d          = JUMP_ADDR;
      instr_valid_d = 1'b0;
      state_d       = ST_RUN;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (HALT_REQ) begin
            // Stop without fetching; a held word stays valid until decode takes it.
            state_d = ST_HALTED;
            if (accept) instr_valid_d = 1'b0;
          end else if (slot_free) begin
            instr_d       = ROM_DATA;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + ADDR_WIDTH'(1);
          end
        end
        ST_HALTED: begin
          if (accept) instr_valid_d = 1'b0;
          if (RESUME && !HALT_REQ) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State register; reset drops any held word immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_VECTOR;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  assign ROM_ADDR    = pc_q;
  assign INSTR       = instr_q;
  assign INSTR_PC    = instr_pc_q;
  assign INSTR_VALID = instr_valid_q;
  assign HALTED      = (state_q == ST_HALTED);
  assign FETCH_CNT   = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Expected fetch addresses go into a scoreboard
// queue as stimulus is issued; a monitor pops and compares on every handshake.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [15:0] rom_addr;
  logic [20:0] rom_data;
  logic [20:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_en;
  logic [15:0] jump_addr;
  logic        halt_req;
  logic        resume;
  logic        halted;
  logic [15:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  instr_fetch #(
    .ROM_WIDTH   (21),
    .ADDR_WIDTH  (16),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .ROM_ADDR   (rom_addr),
    .ROM_DATA   (rom_data),
    .INSTR      (instr),
    .INSTR_PC   (instr_pc),
    .INSTR_VALID(instr_valid),
    .INSTR_READY(instr_ready),
    .JUMP_EN    (jump_en),
    .JUMP_ADDR  (jump_addr),
    .HALT_REQ   (halt_req),
    .RESUME     (resume),
    .HALTED     (halted),
    .FETCH_CNT  (fetch_cnt)
  );

  // Asynchronous ROM: the word at each address is its address tagged with 5'b11101.
  assign rom_data = {5'b11101, rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rom_addr"},    32'(rom_addr),    32'h0000);
    check({tag, "_instr"},       32'(instr),       32'h0);
    check({tag, "_instr_pc"},    32'(instr_pc),    32'h0000);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    check({tag, "_halted"},      32'(halted),      32'h0);
    check({tag, "_fetch_cnt"},   32'(fetch_cnt),   32'h0000);
  endtask

  // Monitor: every completed handshake must match the next expected fetch address.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc 0x%0h expected no handshake", instr_pc);
      end else begin
        logic [15:0] pc;
        pc = exp_q.pop_front();
        check("sb_pc", 32'(instr_pc), 32'(pc));
        check("sb_instr", 32'(instr), 32'(21'h1D0000 | 21'(pc)));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    rst         = 1'b1;
    instr_ready = 1'b1;
    jump_en     = 1'b0;
    jump_addr   = 16'h0000;
    halt_req    = 1'b0;
    resume      = 1'b0;

    // Reset state and the single IDLE cycle, then streaming at full rate.
    repeat (2) tick();
    check_reset_values("reset");
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(i));
    rst = 1'b0;
    tick();
    check("idle_valid", 32'(instr_valid), 32'h0);
    check("idle_rom_addr", 32'(rom_addr), 32'h0000);
    tick();
    check("first_valid", 32'(instr_valid), 32'h1);
    check("first_pc", 32'(instr_pc), 32'h0000);
    check("first_instr", 32'(instr), 32'h1D0000);
    repeat (4) tick();
    check("stream_pc4", 32'(instr_pc), 32'h0004);
    check("stream_cnt", 32'(fetch_cnt), 32'd4);

    // Back-pressure: everything holds for three cycles.
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", 32'(instr_pc), 32'h0004);
      check("stall_instr", 32'(instr), 32'h1D0004);
      check("stall_valid", 32'(instr_valid), 32'h1);
      check("stall_rom_addr", 32'(rom_addr), 32'h0005);
    end
    instr_ready = 1'b1;
    repeat (3) tick();
    check("pre_jump_pc", 32'(instr_pc), 32'h0007);

    // Jump with simultaneous accept of word 7.
    jump_en   = 1'b1;
    jump_addr = 16'h0100;
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0101);
    tick();
    jump_en = 1'b0;
    check("jump_flush_valid", 32'(instr_valid), 32'h0);
    check("jump_cnt", 32'(fetch_cnt), 32'd8);
    check("jump_rom_addr", 32'(rom_addr), 32'h0100);
    tick();
    check("jump_target_pc", 32'(instr_pc), 32'h0100);
    tick();
    check("jump_target_next", 32'(instr_pc), 32'h0101);

    // Jump near the top of the address space: PC wraps.
    jump_en   = 1'b1;
    jump_addr = 16'hFFFE;
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    tick();
    jump_en = 1'b0;
    check("wrap_flush_valid", 32'(instr_valid), 32'h0);
    tick();
    check("wrap_pc_fffe", 32'(instr_pc), 32'hFFFE);
    repeat (2) tick();
    check("wrap_pc_0000", 32'(instr_pc), 32'h0000);
    tick();
    check("wrap_pc_0001", 32'(instr_pc), 32'h0001);

    // Halt while decode stalls; the held word survives until accepted.
    instr_ready = 1'b0;
    halt_req    = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_held_valid", 32'(instr_valid), 32'h1);
    check("halt_held_pc", 32'(instr_pc), 32'h0001);
    check("halt_rom_addr", 32'(rom_addr), 32'h0002);
    tick();
    check("halt_still_valid", 32'(instr_valid), 32'h1);
    instr_ready = 1'b1;
    tick();
    check("halt_drained_valid", 32'(instr_valid), 32'h0);
    check("halt_drained_halted", 32'(halted), 32'h1);
    check("halt_cnt", 32'(fetch_cnt), 32'd14);
    check("halt_rom_addr_frozen", 32'(rom_addr), 32'h0002);
    tick();
    check("halt_no_fetch", 32'(instr_valid), 32'h0);
    check("halt_rom_addr_still", 32'(rom_addr), 32'h0002);

    // Resume continues at the frozen PC after one RUN cycle with no fetch.
    resume = 1'b1;
    for (int i = 2; i < 32; i++) exp_q.push_back(16'(i));
    tick();
    resume = 1'b0;
    check("resume_halted", 32'(halted), 32'h0);
    check("resume_valid", 32'(instr_valid), 32'h0);
    tick();
    check("resume_pc", 32'(instr_pc), 32'h0002);

    // Stream to 0x20, then reset asynchronously before any further edge.
    guard = 0;
    while (instr_pc != 16'h0020 && guard < 100) begin
      tick();
      guard++;
    end
    check("reach_pc_20", 32'(instr_pc), 32'h0020);
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    repeat (2) tick();
    rst = 1'b0;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    tick();
    check("rerun_idle_valid", 32'(instr_valid), 32'h0);
    tick();
    check("rerun_first_pc", 32'(instr_pc), 32'h0000);
    repeat (3) tick();
    instr_ready = 1'b0;
    check("rerun_pc3", 32'(instr_pc), 32'h0003);
    check("rerun_cnt", 32'(fetch_cnt), 32'd3);
    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch unit that reads program memory. It owns the program counter, drives the 16-bit address into the asynchronous instruction ROM, and registers the returned word. The word is presented to the decode stage through a valid/ready handshake. It supports jumps (with flush), halt/resume and a count of delivered instructions.

Parameters:
ROM_WIDTH, 21, instruction word width; must match the ROM data width
ADDR_WIDTH, 16, program counter and ROM address width
RESET_VECTOR, 16'h0000, PC value after reset

Ports:
CLK  in  1  system clock; all state updates on rising edge
RST  in  1  asynchronous, active-high reset
ROM_ADDR  out  ADDR_WIDTH  address to ROM; always equals PC (combinational from PC register)
ROM_DATA  in  ROM_WIDTH  ROM output for ROM_ADDR, valid in the same cycle (asynchronous ROM)
INSTR  out  ROM_WIDTH  registered instruction word
INSTR_PC  out  ADDR_WIDTH  address the word in INSTR was fetched from
INSTR_VALID  out  1  INSTR/INSTR_PC hold a valid instruction
INSTR_READY  in  1  decode accepts INSTR this cycle
JUMP_EN  in  1  single-cycle jump request
JUMP_ADDR  in  ADDR_WIDTH  jump target, sampled when JUMP_EN=1
HALT_REQ  in  1  stop fetching (level or pulse)
RESUME  in  1  leave HALTED, continue at current PC
HALTED  out  1  high while in HALTED state
FETCH_CNT  out  16  number of completed handshakes (INSTR_VALID & INSTR_READY)

Behaviour:
- Reset (async, RST=1): PC=RESET_VECTOR, INSTR=0, INSTR_PC=0, INSTR_VALID=0, HALTED=0, FETCH_CNT=0, state=IDLE. The ROM_ADDR reset value is RESET_VECTOR.
- Reset mid-operation discards any held instruction immediately. There is no partial handshake.
- accept = INSTR_VALID & INSTR_READY. slot_free = ~INSTR_VALID | accept.
- States:
  - IDLE: exactly one cycle after reset release; no fetch. Next state is RUN.
  - RUN: fetches while slot_free.
  - HALTED: no fetch.
- Fetch (RUN, slot_free, no jump): INSTR<=ROM_DATA, INSTR_PC<=PC, INSTR_VALID<=1, PC<=PC+1.
  - Latency: the word at address A appears on INSTR one cycle after PC==A.
  - Throughput is 1 instruction/cycle while INSTR_READY=1.
- Stall (RUN, INSTR_VALID=1, INSTR_READY=0): INSTR, INSTR_PC, INSTR_VALID and PC are all held.
- Accept without refill (HALTED, or HALT_REQ this cycle): INSTR_VALID<=0.
- PC wrap: 16'hFFFF + 1 = 16'h0000. There is no flag or trap.
- Jump (JUMP_EN=1, any state except reset): PC<=JUMP_ADDR, INSTR_VALID<=0 (flush the wrong-path word), state<=RUN.
  - No fetch occurs in the jump cycle. The first word from JUMP_ADDR is valid 2 cycles after the JUMP_EN edge.
- Jump with simultaneous accept: the handshake completes, so FETCH_CNT increments, and the flush still applies.
- Halt: HALT_REQ=1 in RUN (no jump) sends the state to HALTED next cycle. There is no fetch that cycle and PC is held.
  - An instruction already in INSTR stays valid until accepted, then INSTR_VALID<=0.
- HALTED output is 1 exactly while state==HALTED.
- Leaving HALTED:
  - RESUME=1 with HALT_REQ=0 sends the state to RUN; fetch restarts at the held PC.
  - JUMP_EN also leaves HALTED, to RUN at JUMP_ADDR.
  - If RESUME and HALT_REQ are both 1, the block stays HALTED.
- Priority: RST > JUMP_EN > HALT_REQ > RESUME > normal fetch.
- FETCH_CNT increments by 1 on every accept and wraps 16'hFFFF to 0. It is unaffected by jump or halt.

Test Plan:
1. Bench ROM returns {5'b11101, addr}. Release reset with INSTR_READY=1 -> IDLE for 1 cycle; INSTR_PC = 0,1,2,… on consecutive cycles; INSTR = 21'h1D0000, 21'h1D0001,…; FETCH_CNT counts up.
2. Hold INSTR_READY=0 for 3 cycles while INSTR_PC=4 -> INSTR, INSTR_PC=4 and INSTR_VALID stable, ROM_ADDR=5 stable. Release -> next INSTR_PC=5, with no skip or duplicate.
3. JUMP_EN=1, JUMP_ADDR=16'h0100 while INSTR_PC=7 valid and INSTR_READY=1 -> FETCH_CNT +1, INSTR_VALID=0 next cycle, then INSTR_PC=0x0100, 0x0101.
4. Jump to 16'hFFFE -> INSTR_PC sequence FFFE, FFFF, 0000, 0001.
5. Pulse HALT_REQ with INSTR_READY=0 -> HALTED=1, held instruction still valid. Set INSTR_READY=1 -> one accept, then INSTR_VALID=0, ROM_ADDR frozen. Pulse RESUME -> fetch continues at the frozen ROM_ADDR.
6. Assert RST asynchronously mid-stream (INSTR_PC=0x0020) -> all outputs reach their reset values immediately without a clock edge; after release, the first INSTR_PC=RESET_VECTOR following the 1-cycle IDLE.
